// File: rtl/acc_echo_gen.sv
// NoC accelerator tile: buffers one packet, echoes it back to the sender.
// Define ACC_SUM_EN to append a 32-bit checksum word to every response.
module acc_echo_gen #(
  parameter int XY_SZ  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                clk_line,
  input  logic                clk_line_rst_high,
  input  logic [2*XY_SZ-1:0]  HsrcId,
  input  logic                stream_in_TVALID,
  input  logic [DATA_W-1:0]   stream_in_TDATA,
  input  logic [DATA_W/8-1:0] stream_in_TKEEP,
  input  logic                stream_in_TLAST,
  output logic                stream_in_TREADY,
  input  logic                stream_out_TREADY,
  output logic                stream_out_TVALID,
  output logic [DATA_W-1:0]   stream_out_TDATA,
  output logic [DATA_W/8-1:0] stream_out_TKEEP,
  output logic                stream_out_TLAST,
  input  logic                mem_valid_axi,
  input  logic [31:0]         mem_addr_axi,
  input  logic [31:0]         mem_wdata_axi,
  input  logic                mem_wstrb_axi,
  output logic [31:0]         mem_rdata_axi
);

  localparam int KW = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef ACC_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    RX_HDR, RX_DATA, TX_HDR, TX_DATA, TX_SUM
  } state_t;

  localparam state_t TAIL = SUM_EN ? TX_SUM : RX_HDR;

  state_t            state, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [CW-1:0]     idx_q, idx_n;
  logic [DATA_W-1:0] hdr_q;
  logic [DATA_W-1:0] buf_mem [DEPTH];
  logic              dropped;

  logic [31:0] rx_cnt, tx_cnt, drop_cnt;

  logic              valid_d, last_d;
  logic [DATA_W-1:0] data_d;
  logic [KW-1:0]     keep_d;
  logic [DATA_W-1:0] hdr_src, resp;

  logic in_fire, out_fire, hdr_fire;
  logic store, discard, drop_inc;
  logic rx_inc, tx_inc, wr, rd;
  logic [1:0] sel;

  logic unused;
  assign unused = ^{mem_addr_axi[31:4], mem_addr_axi[1:0],
                    mem_wdata_axi, stream_in_TKEEP};

  assign stream_in_TREADY = ~clk_line_rst_high &
                            (state == RX_HDR || state == RX_DATA);

  assign in_fire  = stream_in_TVALID & stream_in_TREADY;
  assign out_fire = stream_out_TVALID & stream_out_TREADY;
  assign hdr_fire = in_fire & (state == RX_HDR);
  assign store    = in_fire & (state == RX_DATA) & (cnt_q != FULL);
  assign discard  = in_fire & (state == RX_DATA) & (cnt_q == FULL);
  assign drop_inc = discard & ~dropped;
  assign rx_inc   = in_fire & stream_in_TLAST;
  assign tx_inc   = out_fire & stream_out_TLAST;

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) state <= RX_HDR;
    else                   state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    unique case (state)
      RX_HDR: if (in_fire) begin
        cnt_n   = '0;
        state_n = stream_in_TLAST ? TX_HDR : RX_DATA;
      end
      RX_DATA: begin
        if (store) cnt_n = cnt_q + CW'(1);
        if (in_fire && stream_in_TLAST) state_n = TX_HDR;
      end
      TX_HDR: if (out_fire) begin
        idx_n   = '0;
        state_n = (cnt_q != '0) ? TX_DATA : TAIL;
      end
      TX_DATA: if (out_fire) begin
        if (idx_q == cnt_q - CW'(1)) state_n = TAIL;
        else                         idx_n = idx_q + CW'(1);
      end
      TX_SUM: if (out_fire) state_n = RX_HDR;
      default: state_n = RX_HDR;
    endcase
  end

`ifdef ACC_SUM_EN
  logic [31:0] sum_q;
  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) sum_q <= '0;
    else if (hdr_fire)     sum_q <= '0;
    else if (store)        sum_q <= sum_q + 32'(stream_in_TDATA);
  end
`endif

  // A header-only packet goes straight to TX_HDR, so use the live beat.
  always_comb begin
    hdr_src = (state == RX_HDR) ? stream_in_TDATA : hdr_q;
    resp    = hdr_src;
    resp[2*XY_SZ-1:0]       = hdr_src[4*XY_SZ-1:2*XY_SZ];
    resp[4*XY_SZ-1:2*XY_SZ] = HsrcId;
  end

  always_comb begin
    valid_d = 1'b0;
    data_d  = '0;
    keep_d  = '0;
    last_d  = 1'b0;
    unique case (state_n)
      TX_HDR: begin
        valid_d = 1'b1;
        keep_d  = {KW{1'b1}};
        data_d  = resp;
        last_d  = ~SUM_EN & (cnt_n == '0);
      end
      TX_DATA: begin
        valid_d = 1'b1;
        keep_d  = {KW{1'b1}};
        data_d  = buf_mem[idx_n[AW-1:0]];
        last_d  = ~SUM_EN & (idx_n == cnt_n - CW'(1));
      end
`ifdef ACC_SUM_EN
      TX_SUM: begin
        valid_d = 1'b1;
        keep_d  = {KW{1'b1}};
        data_d  = DATA_W'(sum_q);
        last_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      stream_out_TVALID <= 1'b0;
      stream_out_TDATA  <= '0;
      stream_out_TKEEP  <= '0;
      stream_out_TLAST  <= 1'b0;
    end else if (!stream_out_TVALID || stream_out_TREADY) begin
      stream_out_TVALID <= valid_d;
      stream_out_TDATA  <= data_d;
      stream_out_TKEEP  <= keep_d;
      stream_out_TLAST  <= last_d;
    end
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      hdr_q   <= '0;
      dropped <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      idx_q <= idx_n;
      if (hdr_fire) begin
        hdr_q   <= stream_in_TDATA;
        dropped <= 1'b0;
      end else if (drop_inc) begin
        dropped <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_line) begin
    if (store) buf_mem[cnt_q[AW-1:0]] <= stream_in_TDATA;
  end

  assign wr  = mem_valid_axi & mem_wstrb_axi;
  assign rd  = mem_valid_axi & ~mem_wstrb_axi;
  assign sel = mem_addr_axi[3:2];

  // A clear from the register port beats a same-cycle increment.
  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      rx_cnt   <= (wr && sel == 2'd1) ? '0 : rx_cnt + 32'(rx_inc);
      tx_cnt   <= (wr && sel == 2'd2) ? '0 : tx_cnt + 32'(tx_inc);
      drop_cnt <= (wr && sel == 2'd3) ? '0 : drop_cnt + 32'(drop_inc);
    end
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      mem_rdata_axi <= '0;
    end else if (rd) begin
      unique case (sel)
        2'd0: mem_rdata_axi <= {31'd0, state != RX_HDR};
        2'd1: mem_rdata_axi <= rx_cnt;
        2'd2: mem_rdata_axi <= tx_cnt;
        2'd3: mem_rdata_axi <= drop_cnt;
        default: mem_rdata_axi <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_echo_gen.sv
// Bench for acc_echo_gen: directed table, hand sequences, random packets.
// Expected responses come from a packet-level model of the echo rules.
module tb_acc_echo_gen;

  localparam int DEP = 16;
`ifdef ACC_SUM_EN
  localparam bit SUM = 1'b1;
`else
  localparam bit SUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  hsrc;
  logic        in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        out_ready, out_valid, out_last;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        m_valid, m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  acc_echo_gen dut (
    .clk_line          (clk),
    .clk_line_rst_high (rst),
    .HsrcId            (hsrc),
    .stream_in_TVALID  (in_valid),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_in_TLAST   (in_last),
    .stream_in_TREADY  (in_ready),
    .stream_out_TREADY (out_ready),
    .stream_out_TVALID (out_valid),
    .stream_out_TDATA  (out_data),
    .stream_out_TKEEP  (out_keep),
    .stream_out_TLAST  (out_last),
    .mem_valid_axi     (m_valid),
    .mem_addr_axi      (m_addr),
    .mem_wdata_axi     (m_wdata),
    .mem_wstrb_axi     (m_wstrb),
    .mem_rdata_axi     (m_rdata)
  );

  typedef struct {
    logic [31:0] hdr;
    int          len;
    logic [31:0] base;
    logic [31:0] step;
    int          mode;
    logic [31:0] exp_hdr;
    int          exp_words;
    logic [31:0] exp_sum;
    int          exp_drop;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int rx_m, tx_m, drop_m;
  logic [31:0] hdr_in;
  logic [31:0] pl[$];
  logic [31:0] exp_d[$];
  bit          exp_l[$];
  vec_t        vt[7];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input bit l, inout int stalls);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) chk("in_ready_timeout", 0, 1);
    stalls += w;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt();
    int stalls = 0;
    tick();
    beat(hdr_in, pl.size() == 0, stalls);
    for (int i = 0; i < pl.size(); i++)
      beat(pl[i], i == pl.size() - 1, stalls);
    chk("hdr_latency_valid", out_valid, 1);
    chk("in_ready_no_stall", stalls, 0);
    rx_m++;
  endtask

  task automatic collect(input int mode);
    int  n = 0;
    int  cyc = 0;
    bit  done = 0;
    bit  pst = 0;
    bit  tog = 0;
    logic [31:0] pd;
    logic        plast;
    while (!done && cyc < 400) begin
      tick();
      tog = ~tog;
      unique case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = tog;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      cyc++;
      if (pst)
        chk("stall_hold", {out_valid, out_last, out_data},
            {1'b1, plast, pd});
      pst   = out_valid && !out_ready;
      pd    = out_data;
      plast = out_last;
      if (out_valid && out_ready) begin
        if (n < exp_d.size())
          chk("out_beat", {out_keep, out_last, out_data},
              {4'hF, exp_l[n], exp_d[n]});
        else
          chk("extra_beat", n, exp_d.size());
        n++;
        if (out_last) done = 1;
      end
    end
    if (!done) chk("out_timeout", 0, 1);
    chk("beat_count", n, exp_d.size());
    tick();
    out_ready = 1'b0;
    chk("in_ready_after_tx", in_ready, 1);
    if (done) tx_m++;
  endtask

  task automatic run_pkt(input int mode);
    fork
      send_pkt();
      collect(mode);
    join
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
    tick();
    m_valid = 1'b1;
    m_wstrb = 1'b0;
    m_addr  = a;
    tick();
    m_valid = 1'b0;
    d = m_rdata;
  endtask

  task automatic reg_wr(input logic [31:0] a);
    tick();
    m_valid = 1'b1;
    m_wstrb = 1'b1;
    m_addr  = a;
    m_wdata = 32'hFFFF_FFFF;
    tick();
    m_valid = 1'b0;
    m_wstrb = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [31:0] a,
                         input int req);
    logic [31:0] d;
    reg_rd(a, d);
    chk(name, d, req);
  endtask

  task automatic chk_counters();
    chk_reg("rx_count", 32'h4, rx_m);
    chk_reg("tx_count", 32'h8, tx_m);
    chk_reg("drop_count", 32'hC, drop_m);
  endtask

  task automatic finish_exp();
    exp_l.delete();
    foreach (exp_d[i]) exp_l.push_back(i == exp_d.size() - 1);
  endtask

  // Reference: swap src into dest, own ID as src, echo what fits, add sum.
  task automatic model(input logic [31:0] h, input logic [7:0] id);
    logic [31:0] sum = 0;
    int n = (pl.size() < DEP) ? pl.size() : DEP;
    exp_d.delete();
    exp_d.push_back((h & 32'hFFFF_0000) | (32'(id) << 8) | ((h >> 8) & 32'hFF));
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(pl[i]);
      sum += pl[i];
    end
    if (SUM) exp_d.push_back(sum);
    finish_exp();
    if (pl.size() > DEP) drop_m++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    vt[0] = '{32'h0000_3412, 3, 1, 1, 0, 32'h0000_2134, 3, 32'd6, 0};
    vt[1] = '{32'hABCD_7856, 0, 0, 0, 0, 32'hABCD_2178, 0, 32'd0, 0};
    vt[2] = '{32'h1234_0000, 20, 1, 0, 0, 32'h1234_2100, 16, 32'd16, 1};
    vt[3] = '{32'hFFFF_FFFF, 16, 32'hFFFF_FFF0, 1, 2,
              32'hFFFF_21FF, 16, 32'hFFFF_FF78, 0};
    vt[4] = '{32'h0000_C3A0, 17, 5, 0, 2, 32'h0000_21C3, 16, 32'h50, 1};
    vt[5] = '{32'h5555_1100, 1, 32'hDEAD_BEEF, 0, 1,
              32'h5555_2111, 1, 32'hDEAD_BEEF, 0};
    vt[6] = '{32'h0000_0000, 4, 10, 3, 1, 32'h0000_2100, 4, 32'h3A, 0};

    rst = 1'b1; hsrc = 8'h21;
    in_valid = 0; in_data = 0; in_keep = 4'hF; in_last = 0;
    out_ready = 0; m_valid = 0; m_wstrb = 0; m_addr = 0; m_wdata = 0;
    rx_m = 0; tx_m = 0; drop_m = 0;

    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_keep", out_keep, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_rdata", m_rdata, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);
    chk_reg("status_idle", 32'h0, 0);
    chk_counters();

    for (int v = 0; v < 7; v++) begin
      hdr_in = vt[v].hdr;
      pl.delete();
      for (int i = 0; i < vt[v].len; i++)
        pl.push_back(vt[v].base + vt[v].step * 32'(i));
      exp_d.delete();
      exp_d.push_back(vt[v].exp_hdr);
      for (int i = 0; i < vt[v].exp_words; i++) exp_d.push_back(pl[i]);
      if (SUM) exp_d.push_back(vt[v].exp_sum);
      finish_exp();
      run_pkt(vt[v].mode);
      drop_m += vt[v].exp_drop;
      chk_counters();
    end

    reg_wr(32'h4);
    rx_m = 0;
    chk_reg("rx_cleared", 32'h4, 0);
    reg_rd(32'h8, d);
    chk("tx_read", d, tx_m);
    repeat (3) tick();
    chk("rdata_hold", m_rdata, tx_m);
    reg_wr(32'h0);
    chk_reg("status_wr_ignored", 32'h0, 0);
    chk_reg("tx_after_reg0_wr", 32'h8, tx_m);

    // Clear of rx lands on the same edge as a packet end.
    tick();
    hdr_in = 32'h0000_6543;
    in_valid = 1; in_data = hdr_in; in_last = 1;
    m_valid = 1; m_wstrb = 1; m_addr = 32'h4;
    tick();
    in_valid = 0; in_last = 0; m_valid = 0; m_wstrb = 0;
    pl.delete();
    model(hdr_in, hsrc);
    chk_reg("clear_beats_inc", 32'h4, 0);
    collect(0);

    for (int r = 0; r < 30; r++) begin
      hsrc   = 8'($urandom);
      hdr_in = $urandom;
      pl.delete();
      for (int i = 0, n = $urandom_range(0, 20); i < n; i++)
        pl.push_back($urandom);
      model(hdr_in, hsrc);
      run_pkt($urandom_range(0, 2));
    end
    chk_counters();

    // Reset in the middle of TX_DATA abandons the response.
    hsrc = 8'h21;
    hdr_in = 32'h0000_3412;
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(32'(i + 100));
    send_pkt();
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    chk_reg("status_busy", 32'h0, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", in_ready, 1);
    rx_m = 0; tx_m = 0; drop_m = 0;
    chk_counters();
    pl.delete();
    for (int i = 0; i < 3; i++) pl.push_back(32'(i + 1));
    model(hdr_in, hsrc);
    run_pkt(1);
    chk_counters();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_echo_gen.md
# acc_echo_gen

Parametrised accelerator-tile datapath that sits behind the tile's NoC stream interface. It accepts one NoC packet at a time (header plus payload), buffers up to DEPTH payload words and returns a response packet to the originating tile. The response carries the echoed payload and, optionally, a checksum word. A small register file on the AXI memory port exposes busy status and packet/drop counters.

## Interface
Parameters:
- XY_SZ, 4, width of one X or Y coordinate
- DATA_W, 32, stream data width; must be a multiple of 8 and at least 4*XY_SZ
- DEPTH, 16, payload buffer depth in words; must be a power of two

Ports:
- clk_line  in  1  single clock; all logic is on this edge
- clk_line_rst_high  in  1  reset; synchronous, active-high
- HsrcId  in  2*XY_SZ  own tile ID: [XY_SZ-1:0]=x, [2*XY_SZ-1:XY_SZ]=y
- stream_in_TVALID / TDATA / TKEEP / TLAST  in  1 / DATA_W / DATA_W/8 / 1  NoC input beat
- stream_in_TREADY  out  1  input ready
- stream_out_TREADY  in  1  downstream ready
- stream_out_TVALID / TDATA / TKEEP / TLAST  out  1 / DATA_W / DATA_W/8 / 1  NoC output beat
- mem_valid_axi  in  1  register access strobe
- mem_addr_axi  in  32  byte address; bits [3:2] select the register
- mem_wdata_axi  in  32  write data
- mem_wstrb_axi  in  1  1 = write, 0 = read
- mem_rdata_axi  out  32  read data

## Operation
- Header word fields: [XY_SZ-1:0]=dest_x, [2XY-1:XY]=dest_y, [3XY-1:2XY]=src_x, [4XY-1:3XY]=src_y. Bits above 4*XY_SZ are opaque.
- FSM states: RX_HDR, RX_DATA, TX_HDR, TX_DATA, TX_SUM. Reset state is RX_HDR.
- RX_HDR:
  - TREADY=1.
  - On an accepted beat, latch the header and clear the word count and sum.
  - If TLAST is set on the header beat, go to TX_HDR. Otherwise go to RX_DATA.
- RX_DATA:
  - TREADY=1.
  - Each accepted beat is written to buffer[count] while count<DEPTH, and count increments.
  - Beats arriving when count==DEPTH are accepted and discarded. The drop counter increments once per packet, not per beat.
  - The checksum is a 32-bit wrapping sum over stored words only, using the low 32 bits of each word.
  - On TLAST go to TX_HDR.
- TX_HDR:
  - TREADY=0.
  - Drive the response header: dest fields = latched src fields, src fields = HsrcId, opaque bits copied from the input header.
  - TLAST=1 only if count==0 and ACC_SUM_EN is undefined.
- TX_DATA:
  - Send buffer[0..count-1].
  - TLAST is set on the final word unless ACC_SUM_EN is defined.
- TX_SUM (ACC_SUM_EN only): send the checksum, zero-extended to DATA_W, with TLAST=1.
- After the TLAST beat is accepted, go to RX_HDR. The rx and tx packet counters increment at packet end.
- Output TKEEP is all ones whenever TVALID=1.
- Registers:
  - addr[3:2]=0: status; bit0 = busy (state is not RX_HDR).
  - addr[3:2]=1: rx packet count.
  - addr[3:2]=2: tx packet count.
  - addr[3:2]=3: drop count.
  - A write to registers 1–3 clears the addressed counter. Writes to register 0 are ignored.
  - All counters are 32-bit and wrap.

## Timing
- Reset (synchronous) values:
  - stream_in_TREADY=0 during the reset cycle, 1 from the first cycle after reset deasserts.
  - stream_out_TVALID=0, TDATA=0, TKEEP=0, TLAST=0.
  - mem_rdata_axi=0.
  - All counters and the checksum are 0; state is RX_HDR.
- Outputs are registered.
- The input TLAST beat is accepted at cycle t. The response header has TVALID=1 at t+1.
- Once TVALID=1, the output TDATA/TLAST are held stable until TREADY=1.
- Output beats run back-to-back at one per cycle while TREADY stays high.
- Minimum packet gap: RX_HDR TREADY=1 in the cycle after the final output beat is accepted.
- Register read: mem_rdata_axi is valid on the cycle after mem_valid_axi=1 with wstrb=0, and holds until the next read.
- A write to a counter in the same cycle that counter would increment: the clear wins, and the counter reads 0.
- Reset asserted mid-packet: the packet is abandoned, partial output is not completed, and the next cycle is as from reset.

## Configuration
- ACC_SUM_EN defined:
  - Every response ends with the TX_SUM checksum word.
  - Response length = input length + 1 (header + stored words + sum).
- ACC_SUM_EN undefined:
  - The TX_SUM state and checksum adder are removed.
  - The response is header plus stored words, with TLAST on the last of them.

## Test plan
- HsrcId=0x21, header 0x0000_3412, payload 1,2,3 (TLAST on 3) → output 0x0000_2134, 1, 2, 3, then 6 with TLAST (SUM_EN) or TLAST on 3 (no SUM_EN); rx=tx=1.
- Header-only packet with TLAST on the header → a single header beat with TLAST (no SUM_EN), or header then 0 with TLAST (SUM_EN).
- DEPTH=16, 20 payload words of value 1 → 16 words echoed, sum=16, drop register=1, TREADY stays 1 for all 21 input beats.
- stream_out_TREADY toggling 1/0 every cycle over a 5-word response → no beat lost or duplicated, and data is stable while stalled.
- Write register 1 while rx is 3, then read register 1 → 0. Read register 0 mid-transmit → bit0=1.
- Assert reset during TX_DATA → TVALID=0 the next cycle. A new packet afterwards is processed correctly with counters at 0.
